// File: rtl/onchip_memory_dp_avalon.sv
// onchip_memory_dp_avalon: true dual-port RAM behind two Avalon-MM slaves with optional zero-clear after reset
module onchip_memory_dp_avalon #(
  parameter int    DATA_WIDTH     = 32,
  parameter int    ADDR_WIDTH     = 16,
  parameter int    DEPTH          = 51200,
  parameter int    READ_LATENCY   = 1,
  parameter int    CLEAR_ON_RESET = 0,
  parameter string INIT_FILE      = "onchip_memory_dp_avalon.hex"
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic                    s1_chipselect,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,
  output logic                    s1_waitrequest,
  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
  input  logic                    s2_chipselect,
  input  logic                    s2_read,
  input  logic                    s2_write,
  input  logic [DATA_WIDTH-1:0]   s2_writedata,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid,
  output logic                    s2_waitrequest,
  output logic                    clear_busy
);
  localparam int BW = DATA_WIDTH / 8;
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] LIM = (ADDR_WIDTH + 1)'(DEPTH);
  typedef enum logic [1:0] {RESET, CLEAR, READY} state_t;
  state_t state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic wait_r, busy_r;
  logic [ADDR_WIDTH-1:0] addr [2];
  logic [BW-1:0] be [2], lane [2];
  logic [DATA_WIDTH-1:0] wdata [2], wval [2], q [2], s1d [2], d2 [2], hold [2], rdata [2];
  logic [IW-1:0] widx [2], ridx [2];
  logic [1:0] cs, rd, wr, in_range, acc_rd, acc_wr, v1, oor1, v2, vout;
  (* ram_init_file = INIT_FILE *) logic [DATA_WIDTH-1:0] mem [DEPTH];
  assign addr  = '{s1_address, s2_address};
  assign be    = '{s1_byteenable, s2_byteenable};
  assign wdata = '{s1_writedata, s2_writedata};
  assign cs = {s2_chipselect, s1_chipselect};
  assign rd = {s2_read, s1_read};
  assign wr = {s2_write, s1_write};
  // Request decode, clear override of port A, and read-data selection with hold
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      in_range[p] = {1'b0, addr[p]} < LIM;
      acc_rd[p] = cs[p] & rd[p] & ~wr[p] & ~wait_r;
      acc_wr[p] = cs[p] & wr[p] & ~wait_r & in_range[p];
      lane[p] = acc_wr[p] ? be[p] : '0;
      widx[p] = addr[p][IW-1:0];
      ridx[p] = addr[p][IW-1:0];
      wval[p] = wdata[p];
      s1d[p] = oor1[p] ? '0 : q[p];
      vout[p] = READ_LATENCY == 2 ? v2[p] : v1[p];
      rdata[p] = vout[p] ? (READ_LATENCY == 2 ? d2[p] : s1d[p]) : hold[p];
    end
    lane[0] = state == CLEAR ? '1 : lane[0];
    widx[0] = state == CLEAR ? cnt[IW-1:0] : widx[0];
    wval[0] = state == CLEAR ? '0 : wval[0];
  end
  // Reset/clear sequencer with registered waitrequest and clear_busy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= CLEAR_ON_RESET != 0 ? CLEAR : RESET;
      cnt    <= '0;
      wait_r <= 1'b1;
      busy_r <= CLEAR_ON_RESET != 0;
    end else begin
      case (state)
        RESET: begin
          state  <= READY;
          wait_r <= 1'b0;
        end
        CLEAR: begin
          if (cnt == ADDR_WIDTH'(DEPTH - 1)) begin
            state  <= READY;
            wait_r <= 1'b0;
            busy_r <= 1'b0;
          end else cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end
  // RAM array: port B written first so port A wins lanes both ports enable
  always_ff @(posedge clk) begin
    for (int p = 1; p >= 0; p--)
      for (int i = 0; i < BW; i++)
        if (lane[p][i]) mem[widx[p]][i*8 +: 8] <= wval[p][i*8 +: 8];
    for (int p = 0; p < 2; p++) q[p] <= mem[ridx[p]];
  end
  // Read pipeline: valid/out-of-range flags, optional output register, held readdata
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1   <= '0;
      oor1 <= '0;
      v2   <= '0;
      d2   <= '{default: '0};
      hold <= '{default: '0};
    end else begin
      v1   <= acc_rd;
      oor1 <= ~in_range;
      v2   <= v1;
      d2   <= s1d;
      hold <= rdata;
    end
  end
  assign s1_readdata      = rdata[0];
  assign s2_readdata      = rdata[1];
  assign s1_readdatavalid = vout[0];
  assign s2_readdatavalid = vout[1];
  assign s1_waitrequest   = wait_r;
  assign s2_waitrequest   = wait_r;
  assign clear_busy       = busy_r;
endmodule
